// File: rtl/clock_pkg.sv
// Shared constants and helpers for the digital clock set/mode controller.
package clock_pkg;

   localparam int unsigned HRS_W = 5;
   localparam int unsigned MIN_W = 6;

   localparam logic [HRS_W-1:0] HRS_MAX = HRS_W'(23);
   localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(59);

   // Controller state doubles as the externally visible mode code.
   typedef enum logic [1:0] {
      MODE_RUN     = 2'd0,
      MODE_SET_HRS = 2'd1,
      MODE_SET_MIN = 2'd2,
      MODE_COMMIT  = 2'd3
   } mode_e;

   // Hours increment with wrap 23 -> 0.
   function automatic logic [HRS_W-1:0] next_hrs(input logic [HRS_W-1:0] h);
      return (h == HRS_MAX) ? '0 : h + HRS_W'(1);
   endfunction

   // Minutes increment with wrap 59 -> 0.
   function automatic logic [MIN_W-1:0] next_min(input logic [MIN_W-1:0] m);
      return (m == MIN_MAX) ? '0 : m + MIN_W'(1);
   endfunction

endpackage

// File: rtl/blink_timer.sv
// Blink phase divider: counts 0..BLINK_CYCLES-1 then toggles the phase.
// Ports:
//   clk, reset   clock, async active-low reset
//   clear        force counter to 0 and phase to "on" on the next edge
//   off_nxt_c    phase value the register takes at the next edge (1 = off/blank)
module blink_timer #(
   parameter int unsigned BLINK_CYCLES = 1,
   parameter int unsigned CNT_W        = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic off_nxt_c
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             off_q;

   // Next counter/phase; exposed so the caller can register blanking in step.
   always_comb begin
      cnt_d     = cnt_q;
      off_nxt_c = off_q;
      if (clear) begin
         cnt_d     = '0;
         off_nxt_c = 1'b0;
      end else if (cnt_q == CNT_W'(BLINK_CYCLES - 1)) begin
         cnt_d     = '0;
         off_nxt_c = ~off_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         off_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         off_q <= off_nxt_c;
      end
   end

endmodule

// File: rtl/clock_set_controller.sv
// Mode/set controller for the digital clock: gates the datapath run enable,
// edits hours/minutes in shadow registers, commits them with a one-cycle load
// pulse, and supplies display values plus blink blanking.
// Ports:
//   clk, reset          clock, async active-low reset
//   btn_mode, btn_inc   single-cycle button pulses
//   cur_hrs, cur_min    live datapath time
//   run_en              datapath seconds-tick enable
//   load, load_hrs/min  commit pulse and values
//   disp_hrs/min        values to display (combinational mux)
//   blank_hrs/min       blank the corresponding digits this cycle
//   mode                0 RUN, 1 SET_HRS, 2 SET_MIN, 3 COMMIT
module clock_set_controller
   import clock_pkg::*;
#(
   parameter int unsigned BLINK_CYCLES   = 1,
   parameter int unsigned TIMEOUT_CYCLES = 30,
   parameter int unsigned CNT_W          = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_mode,
   input  logic             btn_inc,
   input  logic [HRS_W-1:0] cur_hrs,
   input  logic [MIN_W-1:0] cur_min,
   output logic             run_en,
   output logic             load,
   output logic [HRS_W-1:0] load_hrs,
   output logic [MIN_W-1:0] load_min,
   output logic [HRS_W-1:0] disp_hrs,
   output logic [MIN_W-1:0] disp_min,
   output logic             blank_hrs,
   output logic             blank_min,
   output logic [1:0]       mode
);

   mode_e            state_q, state_d;
   logic [HRS_W-1:0] edit_hrs_q, edit_hrs_d;
   logic [MIN_W-1:0] edit_min_q, edit_min_d;
   logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
   logic             run_en_d, load_d, blank_hrs_d, blank_min_d;
   logic             inc_acc_c, in_set_c, next_set_c, blink_clr_c, blink_off_c;

   blink_timer #(
      .BLINK_CYCLES (BLINK_CYCLES),
      .CNT_W        (CNT_W)
   ) u_blink (
      .clk       (clk),
      .reset     (reset),
      .clear     (blink_clr_c),
      .off_nxt_c (blink_off_c)
   );

   // Next state, edit registers, idle timeout and registered outputs.
   always_comb begin
      state_d    = state_q;
      edit_hrs_d = edit_hrs_q;
      edit_min_d = edit_min_q;
      to_cnt_d   = '0;
      inc_acc_c  = 1'b0;

      unique case (state_q)
         MODE_RUN: begin
            if (btn_mode) begin
               state_d    = MODE_SET_HRS;
               edit_hrs_d = cur_hrs;
               edit_min_d = cur_min;
            end
         end
         MODE_SET_HRS: begin
            // Mode wins over a simultaneous inc.
            if (btn_mode) begin
               state_d = MODE_SET_MIN;
            end else if (btn_inc) begin
               edit_hrs_d = next_hrs(edit_hrs_q);
               inc_acc_c  = 1'b1;
            end
         end
         MODE_SET_MIN: begin
            if (btn_mode) begin
               state_d = MODE_COMMIT;
            end else if (btn_inc) begin
               edit_min_d = next_min(edit_min_q);
               inc_acc_c  = 1'b1;
            end
         end
         MODE_COMMIT: state_d = MODE_RUN;
         default:     state_d = MODE_RUN;
      endcase

      // Idle timeout: abort to RUN without a load after TIMEOUT_CYCLES quiet cycles.
      in_set_c = (state_q == MODE_SET_HRS) || (state_q == MODE_SET_MIN);
      if (in_set_c && !btn_mode && !btn_inc) begin
         if (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = MODE_RUN;
         end else begin
            to_cnt_d = to_cnt_q + CNT_W'(1);
         end
      end

      // Blink restarts "on" at state entry, on each accepted inc, and outside SET.
      next_set_c  = (state_d == MODE_SET_HRS) || (state_d == MODE_SET_MIN);
      blink_clr_c = inc_acc_c || (state_d != state_q) || !next_set_c;

      run_en_d    = (state_d == MODE_RUN);
      load_d      = (state_d == MODE_COMMIT);
      blank_hrs_d = (state_d == MODE_SET_HRS) && blink_off_c;
      blank_min_d = (state_d == MODE_SET_MIN) && blink_off_c;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= MODE_RUN;
         edit_hrs_q <= '0;
         edit_min_q <= '0;
         to_cnt_q   <= '0;
         run_en     <= 1'b1;
         load       <= 1'b0;
         blank_hrs  <= 1'b0;
         blank_min  <= 1'b0;
      end else begin
         state_q    <= state_d;
         edit_hrs_q <= edit_hrs_d;
         edit_min_q <= edit_min_d;
         to_cnt_q   <= to_cnt_d;
         run_en     <= run_en_d;
         load       <= load_d;
         blank_hrs  <= blank_hrs_d;
         blank_min  <= blank_min_d;
      end
   end

   assign mode     = state_q;
   assign load_hrs = edit_hrs_q;
   assign load_min = edit_min_q;

   // Display the live time while running, the shadow values otherwise.
   assign disp_hrs = (state_q == MODE_RUN) ? cur_hrs : edit_hrs_q;
   assign disp_min = (state_q == MODE_RUN) ? cur_min : edit_min_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller.
module tb_clock_set_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_mode, btn_inc;
   logic [4:0] cur_hrs;
   logic [5:0] cur_min;
   logic       run_en, load;
   logic [4:0] load_hrs, disp_hrs;
   logic [5:0] load_min, disp_min;
   logic       blank_hrs, blank_min;
   logic [1:0] mode;

   int n_vec  = 0;
   int n_err  = 0;
   int n_load = 0;

   clock_set_controller #(
      .BLINK_CYCLES   (1),
      .TIMEOUT_CYCLES (30),
      .CNT_W          (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_mode  (btn_mode),
      .btn_inc   (btn_inc),
      .cur_hrs   (cur_hrs),
      .cur_min   (cur_min),
      .run_en    (run_en),
      .load      (load),
      .load_hrs  (load_hrs),
      .load_min  (load_min),
      .disp_hrs  (disp_hrs),
      .disp_min  (disp_min),
      .blank_hrs (blank_hrs),
      .blank_min (blank_min),
      .mode      (mode)
   );

   always #5 clk = ~clk;

   // Count load pulses seen at mid-cycle.
   always @(negedge clk) if (load === 1'b1) n_load++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic m, input logic i);
      btn_mode = m;
      btn_inc  = i;
      step();
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
   endtask

   initial begin
      reset    = 1'b0;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      cur_hrs  = 5'd10;
      cur_min  = 6'd15;
      #23;
      chk("rst_mode",   32'(mode),   32'd0);
      chk("rst_run_en", 32'(run_en), 32'd1);
      chk("rst_load",   32'(load),   32'd0);
      chk("rst_blank",  32'({blank_hrs, blank_min}), 32'd0);
      reset = 1'b1;
      step();
      chk("run_mode", 32'(mode),     32'd0);
      chk("run_dh",   32'(disp_hrs), 32'd10);
      chk("run_dm",   32'(disp_min), 32'd15);

      // inc ignored in RUN
      press(1'b0, 1'b1);
      chk("run_inc_mode",   32'(mode),   32'd0);
      chk("run_inc_run_en", 32'(run_en), 32'd1);

      // edit hours 10 -> 13 and commit
      press(1'b1, 1'b0);
      chk("sh_mode",   32'(mode),      32'd1);
      chk("sh_run_en", 32'(run_en),    32'd0);
      chk("sh_dh",     32'(disp_hrs),  32'd10);
      chk("sh_blank",  32'(blank_hrs), 32'd0);
      press(1'b0, 1'b1);
      chk("inc1_dh", 32'(disp_hrs), 32'd11);
      press(1'b0, 1'b1);
      press(1'b0, 1'b1);
      chk("inc3_dh", 32'(disp_hrs), 32'd13);
      press(1'b1, 1'b0);
      chk("sm_mode",   32'(mode),   32'd2);
      chk("sm_run_en", 32'(run_en), 32'd0);
      chk("sm_dm",     32'(disp_min), 32'd15);
      press(1'b1, 1'b0);
      chk("cm_mode",   32'(mode),     32'd3);
      chk("cm_load",   32'(load),     32'd1);
      chk("cm_lh",     32'(load_hrs), 32'd13);
      chk("cm_lm",     32'(load_min), 32'd15);
      chk("cm_run_en", 32'(run_en),   32'd0);
      step();
      chk("post_mode",   32'(mode),   32'd0);
      chk("post_load",   32'(load),   32'd0);
      chk("post_run_en", 32'(run_en), 32'd1);
      chk("post_nload",  32'(n_load), 32'd1);

      // wrap and blink
      cur_hrs = 5'd23;
      cur_min = 6'd59;
      step();
      press(1'b1, 1'b0);
      chk("b0_bh", 32'(blank_hrs), 32'd0);
      step();
      chk("b1_bh", 32'(blank_hrs), 32'd1);
      chk("b1_bm", 32'(blank_min), 32'd0);
      step();
      chk("b2_bh", 32'(blank_hrs), 32'd0);
      step();
      chk("b3_bh", 32'(blank_hrs), 32'd1);
      press(1'b0, 1'b1);
      chk("wrap_dh",  32'(disp_hrs),  32'd0);
      chk("inc_bh",   32'(blank_hrs), 32'd0);
      step();
      chk("b4_bh", 32'(blank_hrs), 32'd1);

      // simultaneous mode + inc: mode wins
      press(1'b1, 1'b1);
      chk("sim_mode", 32'(mode),      32'd2);
      chk("sim_dh",   32'(disp_hrs),  32'd0);
      chk("sim_bh",   32'(blank_hrs), 32'd0);
      chk("sim_bm",   32'(blank_min), 32'd0);
      press(1'b0, 1'b1);
      chk("wrap_dm", 32'(disp_min), 32'd0);
      step();
      chk("bm1", 32'(blank_min), 32'd1);
      chk("bh_in_sm", 32'(blank_hrs), 32'd0);

      // timeout: 30 idle cycles after the last inc
      repeat (28) step();
      chk("to29_mode", 32'(mode), 32'd2);
      step();
      chk("to_mode",   32'(mode),     32'd0);
      chk("to_run_en", 32'(run_en),   32'd1);
      chk("to_dh",     32'(disp_hrs), 32'd23);
      chk("to_dm",     32'(disp_min), 32'd59);
      chk("to_bm",     32'(blank_min), 32'd0);
      chk("to_nload",  32'(n_load),   32'd1);

      // asynchronous reset mid-edit
      press(1'b1, 1'b0);
      chk("ar_pre_mode", 32'(mode), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("ar_mode",   32'(mode),   32'd0);
      chk("ar_run_en", 32'(run_en), 32'd1);
      chk("ar_load",   32'(load),   32'd0);
      reset = 1'b1;
      step();
      chk("ar_post_dh", 32'(disp_hrs), 32'd23);
      chk("ar_nload",   32'(n_load),   32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Mode/set controller for the digital clock datapath (hours/minutes/seconds counters driving the 14-bit two-digit seven-segment codes).
- Takes two single-cycle button pulses (mode, inc), gates the datapath's run enable and edits hours/minutes in shadow registers.
- Commits edits to the datapath with a one-cycle load pulse.
- Supplies display values and blink blanking to the seven-segment encode stage.

Parameters:
- BLINK_CYCLES, 1: clk cycles per blink half-period (on phase, then off phase).
- TIMEOUT_CYCLES, 30: idle clk cycles in a set state before abort back to RUN.
- CNT_W, 8: width of the blink and timeout counters; must hold both values above.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn_mode  in  1  single-cycle pulse: advance mode.
- btn_inc  in  1  single-cycle pulse: increment the field being edited.
- cur_hrs  in  5  live datapath hours, binary 0..23.
- cur_min  in  6  live datapath minutes, binary 0..59.
- run_en  out  1  datapath seconds-tick enable.
- load  out  1  one-cycle pulse: datapath loads load_hrs, load_min and seconds=0.
- load_hrs  out  5  hours value to load.
- load_min  out  6  minutes value to load.
- disp_hrs  out  5  hours to encode for display.
- disp_min  out  6  minutes to encode for display.
- blank_hrs  out  1  blank the hours digits this cycle.
- blank_min  out  1  blank the minutes digits this cycle.
- mode  out  2  state code: 0 RUN, 1 SET_HRS, 2 SET_MIN, 3 COMMIT.

Behaviour:
- Reset (reset=0, asynchronous):
  - State RUN; run_en=1; load=0.
  - edit_hrs, edit_min, blink counter and timeout counter = 0.
  - blank_hrs = blank_min = 0.
- All outputs are registered. disp_hrs and disp_min are combinational muxes only.
- RUN:
  - run_en=1; disp = cur_*.
  - btn_mode -> SET_HRS. On the same edge: edit_hrs<=cur_hrs, edit_min<=cur_min, run_en<=0, counters cleared.
  - btn_inc is ignored.
- SET_HRS:
  - disp_hrs=edit_hrs; disp_min=edit_min; run_en=0.
  - btn_inc: edit_hrs <= (edit_hrs==23) ? 0 : edit_hrs+1.
  - btn_mode -> SET_MIN.
- SET_MIN:
  - btn_inc: edit_min <= (edit_min==59) ? 0 : edit_min+1.
  - btn_mode -> COMMIT.
- COMMIT (exactly one cycle):
  - load=1, load_hrs=edit_hrs, load_min=edit_min; run_en=0.
  - Next cycle: RUN, load=0, run_en=1.
  - Buttons arriving during COMMIT are ignored.
- Simultaneous btn_mode and btn_inc: mode wins; the inc pulse is dropped.
- Blink, SET states only:
  - The counter counts 0..BLINK_CYCLES-1, then toggles the phase. Phase starts "on" (not blanked).
  - blank_hrs = off phase in SET_HRS; blank_min = off phase in SET_MIN; both are 0 elsewhere.
  - On state entry or any accepted btn_inc: counter clears and phase goes "on", so the digit shows solid immediately after a press.
- Timeout, SET states only:
  - Any button pulse clears the idle counter.
  - When the counter reaches TIMEOUT_CYCLES-1 with no button, go to RUN with no load pulse (abort). run_en=1 and edits are discarded.
- During editing, cur_* are frozen by run_en=0. The controller does not sample them after entry.
- Reset mid-edit: immediate RUN with no load.

Decomposition:
- Shared package clock_pkg holds:
  - mode encoding constants: MODE_RUN, MODE_SET_HRS, MODE_SET_MIN, MODE_COMMIT;
  - HRS_MAX=23, MIN_MAX=59;
  - widths HRS_W=5, MIN_W=6.
- One natural sub-module, blink_timer: BLINK_CYCLES divider with clear input and phase output.
- The FSM, edit registers and timeout stay in clock_set_controller.

Test Plan:
- Reset low then high with cur_hrs=10, cur_min=15 -> mode=0, run_en=1, load=0, disp_hrs=10, disp_min=15, no blanking.
- btn_mode, then 3 btn_inc, then btn_mode twice -> edit_hrs 10->13; exactly one load pulse with load_hrs=13, load_min=15; run_en low from SET entry until the cycle after COMMIT.
- cur_hrs=23: enter SET_HRS, one inc -> disp_hrs=0. In SET_MIN with cur_min=59, one inc -> disp_min=0 (wrap both fields).
- btn_mode and btn_inc asserted in the same cycle in SET_HRS -> state becomes SET_MIN and edit_hrs is unchanged.
- Enter SET_MIN, then no buttons for TIMEOUT_CYCLES=30 -> back to RUN, no load pulse, run_en=1, disp = cur values.
- In SET_HRS with BLINK_CYCLES=1 -> blank_hrs toggles every cycle starting at 0, blank_min stays 0. An inc resets blank_hrs to 0. Reset asserted mid-SET -> mode=0 asynchronously.
